// File: rtl/e203_ifu_bhtbpu_pkg.sv
// Shared definitions for the IFU dynamic branch predictor: counter encoding,
// default table/stack sizes and the link-register test.
package e203_ifu_bhtbpu_pkg;

    localparam int BHT_IDX_W_DFLT = 6;
    localparam int RAS_DEPTH_DFLT = 4;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic logic is_link(input logic [4:0] ridx);
        return (ridx == 5'd1) || (ridx == 5'd5);
    endfunction

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken) return (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'b01;
        else       return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/e203_ifu_bpu_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Top is combinational from state; updates land on the next clk edge; flush dominates.
module e203_ifu_bpu_ras #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    input  logic         flush,
    output logic [W-1:0] top,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     ent_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, wr_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;

    assign ptr_inc = ptr_q + PTR_W'(1);
    assign top     = ent_q[ptr_q];
    assign empty   = (cnt_q == '0);

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = ptr_q;
        if (flush) begin
            cnt_d = '0;
        end else if (push && pop) begin
            // call-through-return: the frame is replaced in place
            wr_en = 1'b1;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_ptr = ptr_inc;
            ptr_d  = ptr_inc;
            cnt_d  = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en) ent_q[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// Generic load-enabled flop with asynchronous active-low reset to RST_VAL.
// Latency 1 cycle; no backpressure.
module sirv_gnrl_dfflr #(
    parameter int              DW      = 1,
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst_n
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    qout <= RST_VAL;
        else if (lden) qout <= dnxt;
    end

endmodule

// File: rtl/e203_ifu_bhtbpu.sv
// IFU branch predictor: 2-bit counter BHT for bxx plus a RAS for call/return.
// Prediction is combinational (0 cycles); training/RAS updates on next edge; no backpressure.
module e203_ifu_bhtbpu
    import e203_ifu_bhtbpu_pkg::*;
#(
    parameter int PC_SIZE   = 32,
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = BHT_IDX_W_DFLT,
    parameter int RAS_DEPTH = RAS_DEPTH_DFLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_i_valid,
    input  logic                 dec_i_fire,
    input  logic [PC_SIZE-1:0]   pc,
    input  logic                 dec_rv32,
    input  logic                 dec_jal,
    input  logic                 dec_jalr,
    input  logic                 dec_bxx,
    input  logic [XLEN-1:0]      dec_bjp_imm,
    input  logic [4:0]           dec_rs1idx,
    input  logic [4:0]           dec_rdidx,
    input  logic [XLEN-1:0]      rf2bpu_rs1,
    input  logic                 jalr_dep,
    output logic                 bpu_wait,
    output logic                 prdt_taken,
    output logic [PC_SIZE-1:0]   prdt_pc_add_op1,
    output logic [PC_SIZE-1:0]   prdt_pc_add_op2,
    output logic [BHT_IDX_W-1:0] prdt_bht_idx,
    input  logic                 upd_valid,
    input  logic [BHT_IDX_W-1:0] upd_idx,
    input  logic                 upd_taken,
    input  logic                 ras_flush
);

    localparam int BHT_SIZE = 1 << BHT_IDX_W;

    logic [1:0]         cnt_q [BHT_SIZE];
    logic [1:0]         upd_cnt_d;
    logic [PC_SIZE-1:0] imm_pc, ret_addr, ras_top;
    logic               ras_empty, ras_push, ras_pop;
    logic               rd_link, rs1_link, pop_ok;

    assign prdt_bht_idx = pc[BHT_IDX_W:1];
    assign upd_cnt_d    = cnt_next(cnt_q[upd_idx], upd_taken);

    for (genvar i = 0; i < BHT_SIZE; i++) begin : g_bht
        sirv_gnrl_dfflr #(.DW(2), .RST_VAL(CNT_WNT)) u_cnt (
            .lden  (upd_valid && (upd_idx == BHT_IDX_W'(i))),
            .dnxt  (upd_cnt_d),
            .qout  (cnt_q[i]),
            .clk   (clk),
            .rst_n (rst_n)
        );
    end

    assign imm_pc   = dec_bjp_imm[PC_SIZE-1:0];
    assign ret_addr = pc + (dec_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));
    assign rd_link  = is_link(dec_rdidx);
    assign rs1_link = is_link(dec_rs1idx);
    assign pop_ok   = dec_jalr && rs1_link && (dec_rs1idx != dec_rdidx) && !ras_empty;
    assign ras_push = dec_i_valid && dec_i_fire && (dec_jal || dec_jalr) && rd_link;
    assign ras_pop  = dec_i_valid && dec_i_fire && pop_ok;

    e203_ifu_bpu_ras #(.W(PC_SIZE), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (ret_addr),
        .flush     (ras_flush),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    always_comb begin
        prdt_taken      = 1'b0;
        prdt_pc_add_op1 = pc;
        prdt_pc_add_op2 = '0;
        bpu_wait        = 1'b0;
        if (dec_i_valid) begin
            if (dec_bxx) begin
                prdt_taken      = cnt_q[prdt_bht_idx][1];
                prdt_pc_add_op2 = imm_pc;
            end else if (dec_jal) begin
                prdt_taken      = 1'b1;
                prdt_pc_add_op2 = imm_pc;
            end else if (dec_jalr) begin
                prdt_taken      = 1'b1;
                prdt_pc_add_op2 = imm_pc;
                if (pop_ok) begin
                    prdt_pc_add_op1 = ras_top;
                end else if (dec_rs1idx == 5'd0) begin
                    prdt_pc_add_op1 = '0;
                end else begin
                    prdt_pc_add_op1 = rf2bpu_rs1[PC_SIZE-1:0];
                    bpu_wait        = jalr_dep;
                end
            end
        end
    end

endmodule
